axil_cfg_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator that turns simple command-queue requests into AXI-Lite write/read transactions.
- Used by the transport layer control path to program and read back memory-mapped tables, e.g. the MAC/ID table at 0x200–0x230, without a CPU.
- Each accepted command produces exactly one response carrying read data, the AXI response code and a timeout flag.

---
 rtl/axil_cfg_master.sv | 158 +++++++++++++++
 tb/tb_axil_cfg_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: each accepted command becomes one
// AXI-Lite write or read, and then one response with data, resp code and timeout flag.
module axil_cfg_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic                  m_axi_lite_awvalid,
  input  logic                  m_axi_lite_awready,
  output logic [31:0]           m_axi_lite_wdata,
  output logic [3:0]            m_axi_lite_wstrb,
  output logic                  m_axi_lite_wvalid,
  input  logic                  m_axi_lite_wready,
  input  logic [1:0]            m_axi_lite_bresp,
  input  logic                  m_axi_lite_bvalid,
  output logic                  m_axi_lite_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic                  m_axi_lite_arvalid,
  input  logic                  m_axi_lite_arready,
  input  logic [31:0]           m_axi_lite_rdata,
  input  logic [1:0]            m_axi_lite_rresp,
  input  logic                  m_axi_lite_rvalid,
  output logic                  m_axi_lite_rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  state_t      state;
  logic [31:0] cnt;
  logic        expire;
  logic        aw_fin;
  logic        w_fin;

  // The accept cycle counts as elapsed, so a timed-out command reaches RESP
  // exactly TIMEOUT_CYCLES cycles after it was accepted.
  assign expire = (TMO != 32'd0) && ((cnt + 32'd2) >= TMO);

  assign aw_fin    = !m_axi_lite_awvalid || m_axi_lite_awready;
  assign w_fin     = !m_axi_lite_wvalid  || m_axi_lite_wready;
  assign cmd_ready = reset_n && (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= '0;
      m_axi_lite_awaddr  <= '0;
      m_axi_lite_awvalid <= 1'b0;
      m_axi_lite_wdata   <= '0;
      m_axi_lite_wstrb   <= '0;
      m_axi_lite_wvalid  <= 1'b0;
      m_axi_lite_bready  <= 1'b0;
      m_axi_lite_araddr  <= '0;
      m_axi_lite_arvalid <= 1'b0;
      m_axi_lite_rready  <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= '0;
      rsp_timeout        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cnt <= '0;
            if (cmd_wr) begin
              m_axi_lite_awaddr  <= cmd_addr;
              m_axi_lite_wdata   <= cmd_wdata;
              m_axi_lite_wstrb   <= cmd_wstrb;
              m_axi_lite_awvalid <= 1'b1;
              m_axi_lite_wvalid  <= 1'b1;
              state              <= WR;
            end else begin
              m_axi_lite_araddr  <= cmd_addr;
              m_axi_lite_arvalid <= 1'b1;
              state              <= RD_ADDR;
            end
          end
        end
        WR: begin
          cnt <= cnt + 32'd1;
          if (m_axi_lite_awvalid && m_axi_lite_awready) m_axi_lite_awvalid <= 1'b0;
          if (m_axi_lite_wvalid && m_axi_lite_wready) m_axi_lite_wvalid <= 1'b0;
          if (aw_fin && w_fin) begin
            m_axi_lite_bready <= 1'b1;
            state             <= WR_RESP;
          end else if (expire) begin
            m_axi_lite_awvalid <= 1'b0;
            m_axi_lite_wvalid  <= 1'b0;
            rsp_valid <= 1'b1; rsp_timeout <= 1'b1; rsp_resp <= 2'b10; rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        WR_RESP: begin
          cnt <= cnt + 32'd1;
          if (m_axi_lite_bvalid) begin
            m_axi_lite_bready <= 1'b0;
            rsp_valid <= 1'b1; rsp_timeout <= 1'b0; rsp_resp <= m_axi_lite_bresp; rsp_rdata <= '0;
            state     <= RESP;
          end else if (expire) begin
            m_axi_lite_bready <= 1'b0;
            rsp_valid <= 1'b1; rsp_timeout <= 1'b1; rsp_resp <= 2'b10; rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RD_ADDR: begin
          cnt <= cnt + 32'd1;
          if (m_axi_lite_arready) begin
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_rready  <= 1'b1;
            state              <= RD_DATA;
          end else if (expire) begin
            m_axi_lite_arvalid <= 1'b0;
            rsp_valid <= 1'b1; rsp_timeout <= 1'b1; rsp_resp <= 2'b10; rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RD_DATA: begin
          cnt <= cnt + 32'd1;
          // A data beat arriving in the expiry cycle still completes normally.
          if (m_axi_lite_rvalid) begin
            m_axi_lite_rready <= 1'b0;
            rsp_valid <= 1'b1; rsp_timeout <= 1'b0; rsp_resp <= m_axi_lite_rresp;
            rsp_rdata <= m_axi_lite_rdata;
            state     <= RESP;
          end else if (expire) begin
            m_axi_lite_rready <= 1'b0;
            rsp_valid <= 1'b1; rsp_timeout <= 1'b1; rsp_resp <= 2'b10; rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Randomized bench for axil_cfg_master: a delay-programmable AXI-Lite slave plus a
// transaction-level model of the expected response contents and latency.
module tb_axil_cfg_master;
  localparam int AW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp = '0;
  logic          bvalid = 1'b0, bready;
  logic          arvalid, arready = 1'b0;
  logic [31:0]   rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rvalid = 1'b0, rready;

  axil_cfg_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid),
    .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid),
    .m_axi_lite_bready(bready), .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid),
    .m_axi_lite_arready(arready), .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
    .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  // Slave knobs per transaction and slave-side bookkeeping
  int          da, dw, db, dar, dr;
  bit          ar_block;
  logic [1:0]  bresp_sel, rresp_sel;
  int          aw_cnt, w_cnt, ar_cnt, b_tmr, r_tmr, aw_hi, w_hi;
  bit          aw_done, w_done, b_armed, b_hs, r_armed, r_hs, aw_wait, ar_wait;
  logic [31:0] s_addr, s_wdata, s_raddr, awaddr_prev, wdata_prev, araddr_prev;
  logic [3:0]  s_wstrb;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'd0;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    if (slave_mem.exists(a)) return slave_mem[a];
    return 32'd0;
  endfunction

  task automatic slave_clear();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_tmr = 0; r_tmr = 0; aw_hi = 0; w_hi = 0;
    aw_done = 0; w_done = 0; b_armed = 0; b_hs = 0; r_armed = 0; r_hs = 0;
    aw_wait = 0; ar_wait = 0;
  endtask

  // One clock: wake at the falling edge, check protocol, then drive this cycle's slave inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bready) check_eq("bready_after_aw_w", 32'(aw_done && w_done), 32'd1);
    if (aw_wait && awvalid) begin
      check_eq("awaddr_stable", awaddr, awaddr_prev);
      check_eq("wdata_stable", wdata, wdata_prev);
    end
    if (ar_wait && arvalid) check_eq("araddr_stable", araddr, araddr_prev);
    if (b_hs) begin bvalid = 0; b_hs = 0; b_armed = 0; aw_done = 0; w_done = 0; end
    if (r_hs) begin rvalid = 0; r_hs = 0; r_armed = 0; end
    if (b_armed && !bvalid) begin
      if (b_tmr == 0) begin bvalid = 1; bresp = bresp_sel; end else b_tmr--;
    end
    if (bvalid && bready) begin
      b_hs = 1;
      slave_mem[s_addr] = merge(slv_rd(s_addr), s_wdata, s_wstrb);
    end
    if (r_armed && !rvalid) begin
      if (r_tmr == 0) begin rvalid = 1; rdata = slv_rd(s_raddr); rresp = rresp_sel; end
      else r_tmr--;
    end
    if (rvalid && rready) r_hs = 1;
    awready = awvalid && (aw_cnt >= da);
    wready  = wvalid && (w_cnt >= dw);
    arready = arvalid && !ar_block && (ar_cnt >= dar);
    if (awvalid) begin
      aw_hi++;
      if (awready) begin aw_done = 1; s_addr = awaddr; end else aw_cnt++;
    end
    if (wvalid) begin
      w_hi++;
      if (wready) begin w_done = 1; s_wdata = wdata; s_wstrb = wstrb; end else w_cnt++;
    end
    if (arvalid) begin
      if (arready) begin s_raddr = araddr; r_armed = 1; r_tmr = dr; end else ar_cnt++;
    end
    if (aw_done && w_done && !b_armed) begin b_armed = 1; b_tmr = db; end
    aw_wait = awvalid && !awready; awaddr_prev = awaddr; wdata_prev = wdata;
    ar_wait = arvalid && !arready; araddr_prev = araddr;
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, output int acc);
    int n;
    slave_clear();
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    acc = cyc;
    step();
    cmd_valid = 0;
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold);
    logic [31:0] exp_rdata, s_rd;
    logic [1:0]  exp_resp, s_rs;
    bit          exp_to, s_to;
    int          exp_lat, acc;
    exp_rdata = 32'd0;
    exp_to    = 1'b0;
    if (!wr && ar_block) begin
      exp_lat = TMO; exp_resp = 2'b10; exp_to = 1'b1;
    end else if (wr) begin
      exp_lat = 3 + ((da > dw) ? da : dw) + db; exp_resp = bresp_sel;
      ref_mem[addr] = merge(ref_rd(addr), wd, ws);
    end else begin
      exp_lat = 3 + dar + dr; exp_resp = rresp_sel; exp_rdata = ref_rd(addr);
    end
    issue(wr, addr, wd, ws, acc);
    while (!rsp_valid && (cyc - acc) < 100) step();
    check_eq("rsp_latency", 32'(cyc - acc), 32'(exp_lat));
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    check_eq("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
    check_eq("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    if (exp_to) check_eq("valids_dropped", 32'({arvalid, awvalid, wvalid, bready, rready}), 32'd0);
    else if (wr) begin
      check_eq("awvalid_cycles", 32'(aw_hi), 32'(da + 1));
      check_eq("wvalid_cycles", 32'(w_hi), 32'(dw + 1));
    end
    s_rd = rsp_rdata; s_rs = rsp_resp; s_to = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 0;
      step();
      check_eq("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rsp_fields", {rsp_rdata[29:0], rsp_resp} ^ {30'd0, s_to, 1'b0},
               {s_rd[29:0], s_rs} ^ {30'd0, rsp_timeout, 1'b0});
      check_eq("hold_busy_cmd_ready", 32'({busy, cmd_ready}), 32'b10);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check_eq("rsp_dropped", 32'(rsp_valid), 32'd0);
    check_eq("idle_cmd_ready", 32'({busy, cmd_ready}), 32'b01);
  endtask

  initial begin
    int  acc;
    bit  saw_rsp;
    logic [31:0] a;
    da = 0; dw = 0; db = 0; dar = 0; dr = 0; ar_block = 0; bresp_sel = 0; rresp_sel = 0;
    slave_clear();
    step(); step();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy}), 32'd0);
    check_eq("rst_awaddr", awaddr, 32'd0);
    check_eq("rst_rsp_fields", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    reset_n = 1;
    step();
    check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Slave always ready
    do_txn(1, 32'h200, 32'h33221100, 4'hf, 0);
    // Write then read back
    do_txn(1, 32'h230, 32'h5, 4'hf, 0);
    do_txn(0, 32'h230, 32'h0, 4'h0, 0);
    check_eq("readback_mem", slv_rd(32'h230), 32'h5);
    // AW stalled three cycles, W immediate
    da = 3;
    do_txn(1, 32'h204, 32'hcafef00d, 4'h5, 0);
    da = 0;
    // Read address never accepted
    ar_block = 1;
    do_txn(0, 32'h208, 32'h0, 4'h0, 0);
    ar_block = 0;
    // Response back-pressure
    rresp_sel = 2'b01;
    do_txn(0, 32'h200, 32'h0, 4'h0, 5);
    rresp_sel = 2'b00;

    // Reset while AW/W are pending
    da = 5; dw = 5;
    issue(1, 32'h210, 32'hdeadbeef, 4'hf, acc);
    check_eq("pre_rst_awvalid", 32'({awvalid, wvalid}), 32'b11);
    reset_n = 0;
    #1;
    check_eq("mid_rst_outputs", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}), 32'd0);
    slave_clear();
    da = 0; dw = 0;
    step(); step();
    reset_n = 1;
    step();
    check_eq("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
    saw_rsp = 0;
    for (int i = 0; i < 10; i++) begin step(); if (rsp_valid) saw_rsp = 1; end
    check_eq("no_stale_rsp", 32'(saw_rsp), 32'd0);

    // Randomized traffic over the MAC/ID table window
    for (int t = 0; t < 40; t++) begin
      da = $urandom_range(0, 5); dw = $urandom_range(0, 5); db = $urandom_range(0, 5);
      dar = $urandom_range(0, 5); dr = $urandom_range(0, 5);
      bresp_sel = 2'($urandom_range(0, 3)); rresp_sel = 2'($urandom_range(0, 3));
      a = 32'h200 + 32'(4 * $urandom_range(0, 12));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
